// File: rtl/output_drain_control.sv
// Output drain control: walks the accumulator rows of a finished submatrix,
// issuing one row read per unstalled cycle and producing the matching
// per-lane output-memory writes PIPE_DEPTH cycles later.
module output_drain_control #(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int PIPE_DEPTH   = 2,
  parameter int SUBMAT_W     = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [SUBMAT_W-1:0]                  submat_row_in,
  input  logic [SUBMAT_W-1:0]                  submat_col_in,
  input  logic [$clog2(SYS_ARR_ROWS):0]        num_rows,
  input  logic [$clog2(SYS_ARR_COLS):0]        num_cols,
  input  logic                                 activate,
  input  logic                                 clear_after,
  input  logic [ADDR_WIDTH-1:0]                wr_base_addr,
  input  logic [ADDR_WIDTH-1:0]                wr_stride,
  input  logic                                 stall,
  output logic [SUBMAT_W-1:0]                  submat_row_out,
  output logic [SUBMAT_W-1:0]                  submat_col_out,
  output logic                                 rd_en,
  output logic [$clog2(SYS_ARR_ROWS)-1:0]      row_num,
  output logic [SYS_ARR_COLS-1:0]              wr_en,
  output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0]   wr_addr,
  output logic                                 relu_en,
  output logic                                 accum_reset,
  output logic                                 busy,
  output logic                                 done
);

  localparam int RW  = $clog2(SYS_ARR_ROWS);
  localparam int NRW = RW + 1;
  localparam int NCW = $clog2(SYS_ARR_COLS) + 1;
  localparam int FCW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  // One in-flight row read travelling towards the memory port.
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] row;
    logic          last;
  } slot_t;

  state_t                state_q, state_d;
  logic [SUBMAT_W-1:0]   sub_row_q, sub_col_q;
  logic [NRW-1:0]        rows_q, rows_clamped;
  logic [NCW-1:0]        cols_q, cols_clamped;
  logic                  act_q, clr_q;
  logic [ADDR_WIDTH-1:0] base_q, stride_q, row_addr;
  logic [RW-1:0]         count_q;
  logic [FCW-1:0]        flush_q;
  logic                  zero_done_q;
  logic                  accept, zero_job, issue_last, wr_fire;
  slot_t                 issue_slot, d_slot;

  assign rows_clamped = (num_rows > NRW'(SYS_ARR_ROWS)) ? NRW'(SYS_ARR_ROWS) : num_rows;
  assign cols_clamped = (num_cols > NCW'(SYS_ARR_COLS)) ? NCW'(SYS_ARR_COLS) : num_cols;
  assign accept       = (state_q == IDLE) && start;
  assign zero_job     = (rows_clamped == '0) || (cols_clamped == '0);
  assign issue_last   = ({1'b0, count_q} == rows_q - 1'b1);

  assign issue_slot.valid = (state_q == ISSUE) && !stall;
  assign issue_slot.row   = count_q;
  assign issue_slot.last  = issue_last;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and the FSM-level outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    busy    = (state_q != IDLE);
    rd_en   = issue_slot.valid;
    unique case (state_q)
      IDLE:  if (start && !zero_job) state_d = ISSUE;
      ISSUE: if (!stall && issue_last) state_d = (PIPE_DEPTH == 0) ? IDLE : FLUSH;
      FLUSH: if (!stall && flush_q == FCW'(PIPE_DEPTH - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job latch and row issue counter; job fields only move on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_row_q <= '0;
      sub_col_q <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      act_q     <= 1'b0;
      clr_q     <= 1'b0;
      base_q    <= '0;
      stride_q  <= '0;
      count_q   <= '0;
    end else if (accept) begin
      sub_row_q <= submat_row_in;
      sub_col_q <= submat_col_in;
      rows_q    <= rows_clamped;
      cols_q    <= cols_clamped;
      act_q     <= activate;
      clr_q     <= clear_after;
      base_q    <= wr_base_addr;
      stride_q  <= wr_stride;
      count_q   <= '0;
    end else if (issue_slot.valid) begin
      count_q   <= issue_last ? '0 : count_q + 1'b1;
    end
  end

  // Flush counter plus the held done request for empty jobs.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_q     <= '0;
      zero_done_q <= 1'b0;
    end else begin
      if (state_q != FLUSH) flush_q <= '0;
      else if (!stall)      flush_q <= flush_q + 1'b1;
      if (accept && zero_job) zero_done_q <= 1'b1;
      else if (!stall)        zero_done_q <= 1'b0;
    end
  end

  // Read-to-write delay line; frozen as a whole while the memory stalls.
  generate
    if (PIPE_DEPTH == 0) begin : g_no_pipe
      assign d_slot = issue_slot;
    end else begin : g_pipe
      slot_t pipe_q [PIPE_DEPTH];
      // Shift one slot per unstalled cycle.
      always_ff @(posedge clk) begin
        // NOTE: this small array is reset explicitly; stale valid bits would
        // otherwise fire writes after a mid-job abort.
        if (reset) begin
          for (int i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= '0;
        end else if (!stall) begin
          pipe_q[0] <= issue_slot;
          for (int i = 1; i < PIPE_DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign d_slot = pipe_q[PIPE_DEPTH-1];
    end
  endgenerate

  assign wr_fire  = d_slot.valid && !stall;
  assign row_addr = base_q + ADDR_WIDTH'(d_slot.row) * stride_q;

  // Write-side outputs, all gated by the delayed valid and stall.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < SYS_ARR_COLS; i++) begin
      if (wr_fire && (i < int'(cols_q))) wr_en[i] = 1'b1;
    end
    wr_addr     = {SYS_ARR_COLS{row_addr}};
    relu_en     = wr_fire && act_q;
    accum_reset = wr_fire && d_slot.last && clr_q;
    done        = (wr_fire && d_slot.last) || (zero_done_q && !stall);
  end

  assign row_num        = count_q;
  assign submat_row_out = sub_row_q;
  assign submat_col_out = sub_col_q;

endmodule

// File: tb/tb_output_drain_control.sv
// Directed bench for output_drain_control with default parameters.
module tb_output_drain_control;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int AW   = 8;
  localparam int PD   = 2;
  localparam int SW   = 3;

  logic              clk = 1'b0;
  logic              reset, start, activate, clear_after, stall;
  logic [SW-1:0]     submat_row_in, submat_col_in, submat_row_out, submat_col_out;
  logic [4:0]        num_rows, num_cols;
  logic [AW-1:0]     wr_base_addr, wr_stride;
  logic              rd_en, relu_en, accum_reset, busy, done;
  logic [3:0]        row_num;
  logic [COLS-1:0]   wr_en;
  logic [COLS*AW-1:0] wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  output_drain_control #(
    .SYS_ARR_ROWS(ROWS), .SYS_ARR_COLS(COLS), .ADDR_WIDTH(AW),
    .PIPE_DEPTH(PD), .SUBMAT_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .submat_row_in(submat_row_in), .submat_col_in(submat_col_in),
    .num_rows(num_rows), .num_cols(num_cols),
    .activate(activate), .clear_after(clear_after),
    .wr_base_addr(wr_base_addr), .wr_stride(wr_stride), .stall(stall),
    .submat_row_out(submat_row_out), .submat_col_out(submat_col_out),
    .rd_en(rd_en), .row_num(row_num), .wr_en(wr_en), .wr_addr(wr_addr),
    .relu_en(relu_en), .accum_reset(accum_reset), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Runs one job and scores every cycle until done or a cycle budget expires.
  task automatic run_job(input int rows, input int cols, input logic [7:0] base,
                         input logic [7:0] stride, input logic act, input logic clr,
                         input logic [SW-1:0] sr, input logic [SW-1:0] sc,
                         input int exp_rows, input int exp_cols,
                         input int stall_after, input int stall_len, input bit poke);
    int rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, stalled = 0, cyc = 0;
    bit fin = 0, poked = 0;
    logic [15:0] mask;
    logic [7:0]  a;
    mask = 16'((32'h1 << exp_cols) - 1);
    @(negedge clk);
    start = 1'b1; num_rows = 5'(rows); num_cols = 5'(cols);
    wr_base_addr = base; wr_stride = stride; activate = act; clear_after = clr;
    submat_row_in = sr; submat_col_in = sc;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 100) begin
      stall = (stall_len > 0) && (rd_cnt == stall_after) && (stalled < stall_len);
      if (poke && !poked && rd_cnt == 1) begin
        start = 1'b1; num_rows = 5'd1; num_cols = 5'd1;
        submat_row_in = ~sr; submat_col_in = ~sc; poked = 1;
      end
      #1;
      if (stall) begin
        stalled++;
        check("stall_rd_en", rd_en, 0);
        check("stall_wr_en", wr_en, 0);
        check("stall_done", done, 0);
      end
      if (busy) busy_cnt++;
      if (rd_en) begin
        check("row_num", row_num, rd_cnt);
        rd_cnt++;
      end
      if (wr_en != 0) begin
        a = base + wr_cnt * stride;
        check("wr_en", wr_en, mask);
        check("wr_addr", wr_addr, {COLS{a}});
        check("relu_en", relu_en, act);
        check("accum_reset", accum_reset, clr && (wr_cnt == exp_rows - 1));
        check("done_at_write", done, wr_cnt == exp_rows - 1);
        if (done) fin = 1;
        wr_cnt++;
      end else begin
        check("idle_relu", relu_en, 0);
        check("idle_accum", accum_reset, 0);
        check("idle_done", done, 0);
      end
      cyc++;
      @(negedge clk);
      start = 1'b0; stall = 1'b0;
    end
    check("job_timeout", fin, 1);
    check("write_count", wr_cnt, exp_rows);
    check("read_count", rd_cnt, exp_rows);
    check("busy_cycles", busy_cnt, exp_rows + PD + stall_len);
    #1;
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("submat_row_out", submat_row_out, sr);
    check("submat_col_out", submat_col_out, sc);
  endtask

  // Empty job: no writes, done one cycle after start.
  task automatic zero_job(input int rows, input int cols);
    @(negedge clk);
    start = 1'b1; num_rows = 5'(rows); num_cols = 5'(cols);
    #1;
    check("zero_busy_start", busy, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_wr_en", wr_en, 0);
    check("zero_rd_en", rd_en, 0);
    @(negedge clk);
    #1;
    check("zero_done_once", done, 0);
  endtask

  initial begin
    bit found = 0;
    reset = 1'b1; start = 1'b0; stall = 1'b0; activate = 1'b0; clear_after = 1'b0;
    submat_row_in = '0; submat_col_in = '0; num_rows = '0; num_cols = '0;
    wr_base_addr = '0; wr_stride = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_relu", relu_en, 0);
    check("rst_accum", accum_reset, 0);
    check("rst_submat", {submat_row_out, submat_col_out}, 0);

    // Full job with relu and clear-after.
    run_job(16, 16, 8'h10, 8'h01, 1, 1, 3'd2, 3'd5, 16, 16, 0, 0, 0);
    // Partial job with address wrap, no relu, no clear.
    run_job(3, 5, 8'hF8, 8'h04, 0, 0, 3'd1, 3'd6, 3, 5, 0, 0, 0);
    // Three-cycle stall after row 2 issues.
    run_job(16, 16, 8'h20, 8'h02, 1, 0, 3'd7, 3'd0, 16, 16, 3, 3, 0);
    // Second start mid-job is ignored.
    run_job(4, 2, 8'h40, 8'h03, 0, 1, 3'd3, 3'd4, 4, 2, 0, 0, 1);
    // Oversized request clamps to the array size.
    run_job(31, 20, 8'h00, 8'h11, 1, 1, 3'd5, 3'd2, 16, 16, 0, 0, 0);

    zero_job(0, 4);
    zero_job(5, 0);

    // Abort with reset once row 7 is issued.
    @(negedge clk);
    start = 1'b1; num_rows = 5'd16; num_cols = 5'd16; wr_base_addr = 8'h00; wr_stride = 8'h01;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      #1;
      if (rd_en && row_num == 4'd7) found = 1;
      else @(negedge clk);
    end
    check("reach_row7", found, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_done", done, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("abort_quiet_wr", wr_en, 0);
      check("abort_quiet_done", done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
